// File: rtl/clock_set_pkg.sv
// ============================================================================
// Module  : clock_set_pkg
// Brief   : Shared mode encodings for the digital-clock set controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_set_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_SEC  = 2'b11
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/clock_set_ctrl_btn_event.sv
// ============================================================================
// Module  : btn_event
// Brief   : Registered press-event detector for one debounced button, with an
//           optional hold-to-repeat generator (CLOCK_SET_AUTOREP_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_event #(
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
`ifdef CLOCK_SET_AUTOREP_EN
    input  logic i_rep_ok,
`endif
    output logic o_evt
);

    logic r_prev;
    logic r_evt;
    logic w_press;

    assign w_press = i_level & ~r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_prev <= i_level;
            r_evt  <= w_press;
        end
    end

`ifdef CLOCK_SET_AUTOREP_EN
    localparam int c_CNT_W = $clog2(REPEAT_DLY + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rep;

    // After the first repeat the counter reloads so later pulses are REPEAT_PER apart.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end else if (w_press) begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end else if (i_level && i_rep_ok) begin
            if (r_cnt == c_CNT_W'(REPEAT_DLY - 1)) begin
                r_cnt <= c_CNT_W'(REPEAT_DLY - REPEAT_PER);
                r_rep <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_rep <= 1'b0;
            end
        end else begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end
    end

    assign o_evt = r_evt | r_rep;
`else
    assign o_evt = r_evt;
`endif

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// Module  : clock_set_ctrl
// Brief   : Run/set mode sequencer for the seconds/minutes/hours counters.
//           Optional hold-to-repeat on SET_BTN via CLOCK_SET_AUTOREP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int TIMEOUT_S  = 30,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TICK_1HZ,
    input  logic              MODE_BTN,
    input  logic              SET_BTN,
    input  logic              SEC_CA,
    input  logic              MIN_CA,
    output logic              SEC_EN,
    output logic              MIN_EN,
    output logic              HOUR_EN,
    output logic              MIN_INC,
    output logic              HOUR_INC,
    output logic              SEC_CLR,
    output logic [MODE_W-1:0] MODE,
    output logic              BLINK
);

    localparam int c_TMO_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

    mode_e              r_mode;
    mode_e              w_mode_nxt;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_blink;
    logic               w_mode_evt;
    logic               w_set_evt;
    logic               w_in_set;
    logic               w_tmo_hit;

    assign w_in_set  = (r_mode != MODE_RUN);
    assign w_tmo_hit = (TIMEOUT_S != 0) && w_in_set && (r_tmo == c_TMO_W'(TIMEOUT_S));

    btn_event #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_mode_btn (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_level  (MODE_BTN),
`ifdef CLOCK_SET_AUTOREP_EN
        .i_rep_ok (1'b0),
`endif
        .o_evt    (w_mode_evt)
    );

    btn_event #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_set_btn (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_level  (SET_BTN),
`ifdef CLOCK_SET_AUTOREP_EN
        .i_rep_ok ((r_mode == MODE_SET_HOUR) || (r_mode == MODE_SET_MIN)),
`endif
        .o_evt    (w_set_evt)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        SEC_EN     = 1'b0;
        MIN_EN     = 1'b0;
        HOUR_EN    = 1'b0;
        MIN_INC    = 1'b0;
        HOUR_INC   = 1'b0;
        SEC_CLR    = 1'b0;

        if (w_mode_evt) begin
            case (r_mode)
                MODE_RUN:      w_mode_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: w_mode_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  w_mode_nxt = MODE_SET_SEC;
                default:       w_mode_nxt = MODE_RUN;
            endcase
        end else if (w_tmo_hit) begin
            w_mode_nxt = MODE_RUN;
        end

        // Counter controls are held off while reset is asserted.
        if (RST) begin
            case (r_mode)
                MODE_RUN: begin
                    SEC_EN  = TICK_1HZ;
                    MIN_EN  = SEC_CA;
                    HOUR_EN = MIN_CA;
                end
                MODE_SET_HOUR: HOUR_INC = w_set_evt;
                MODE_SET_MIN:  MIN_INC  = w_set_evt;
                default:       SEC_CLR  = w_set_evt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_tmo <= '0;
        end else if (!w_in_set || w_mode_evt || w_set_evt || (w_mode_nxt != r_mode)) begin
            r_tmo <= '0;
        end else if (TICK_1HZ && (r_tmo != c_TMO_W'(TIMEOUT_S))) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_blink <= 1'b0;
        end else if (w_mode_nxt != r_mode) begin
            r_blink <= (w_mode_nxt != MODE_RUN);
        end else if (!w_in_set) begin
            r_blink <= 1'b0;
        end else if (TICK_1HZ) begin
            r_blink <= ~r_blink;
        end
    end

    assign MODE  = r_mode;
    assign BLINK = r_blink;

endmodule

`default_nettype wire
